// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between the two sample producers, the arbiter and the FIFO write port.
// The arbiter uses the master modport; the producer/FIFO side uses slave.
interface fifo_write_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic [WIDTH-1:0] fifo_wdata;
    logic             fifo_winc;
    logic             fifo_wfull;
    logic [1:0]       grant;

    modport master (
        input  req0_valid, req0_data,
        input  req1_valid, req1_data,
        input  fifo_wfull,
        output req0_ready, req1_ready,
        output fifo_wdata, fifo_winc,
        output grant
    );

    modport slave (
        output req0_valid, req0_data,
        output req1_valid, req1_data,
        output fifo_wfull,
        input  req0_ready, req1_ready,
        input  fifo_wdata, fifo_winc,
        input  grant
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing the block_fifo write port between two producers.
// Define FIFO_ARB_TAG_EN to prefix every burst with a tag byte (8'hA0 | requester).
module fifo_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    fifo_write_arbiter_if.master arb_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef FIFO_ARB_TAG_EN
        TAG  = 2'd1,
`endif
        DATA = 2'd2
    } state_t;

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

`ifdef FIFO_ARB_TAG_EN
    localparam state_t FIRST = TAG;
`else
    localparam state_t FIRST = DATA;
`endif

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;

    logic             sel;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic [3:0]       cnt_inc;
    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             ready0;
    logic             ready1;

    assign sel       = grant_q[1];
    assign sel_valid = sel ? arb_if.req1_valid : arb_if.req0_valid;
    assign sel_data  = sel ? arb_if.req1_data : arb_if.req0_data;
    assign cnt_inc   = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        winc    = 1'b0;
        wdata   = '0;
        ready0  = 1'b0;
        ready1  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                // last_q == 1 means requester 0 wins a tie
                if (arb_if.req0_valid && (!arb_if.req1_valid || last_q)) begin
                    grant_d = 2'b01;
                    state_d = FIRST;
                end else if (arb_if.req1_valid) begin
                    grant_d = 2'b10;
                    state_d = FIRST;
                end
            end
`ifdef FIFO_ARB_TAG_EN
            TAG: begin
                winc = ~arb_if.fifo_wfull;
                if (!arb_if.fifo_wfull) begin
                    wdata   = WIDTH'(8'hA0 | {7'd0, sel});
                    state_d = DATA;
                end
            end
`endif
            DATA: begin
                ready0 = ~sel & ~arb_if.fifo_wfull;
                ready1 = sel & ~arb_if.fifo_wfull;
                if (sel_valid && !arb_if.fifo_wfull) begin
                    winc  = 1'b1;
                    wdata = sel_data;
                    cnt_d = cnt_inc;
                    if (cnt_inc == MAXB) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        last_d  = sel;
                    end
                end else if (!sel_valid) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    last_d  = sel;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Reset forces the outputs low at once, not only after the next edge
    assign arb_if.fifo_winc  = winc & ~rst;
    assign arb_if.fifo_wdata = rst ? '0 : wdata;
    assign arb_if.req0_ready = ready0 & ~rst;
    assign arb_if.req1_ready = ready1 & ~rst;
    assign arb_if.grant      = grant_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (WIDTH=8, MAX_BURST=4), with or without FIFO_ARB_TAG_EN.
module tb_fifo_write_arbiter;

`ifdef FIFO_ARB_TAG_EN
    localparam int TAGN = 1;
`else
    localparam int TAGN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.WIDTH(8)) vif ();

    fifo_write_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (vif.master)
    );

    int total = 0;
    int bad   = 0;
    int rem0  = 0;
    int rem1  = 0;

    logic [1:0] g_s;
    logic       w_s;
    logic [7:0] wd_s;
    logic       r0_s;
    logic       r1_s;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    task automatic drive();
        vif.req0_valid = (rem0 > 0);
        vif.req1_valid = (rem1 > 0);
    endtask

    task automatic cycle();
        logic a0, a1;
        @(negedge clk);
        g_s  = vif.grant;
        w_s  = vif.fifo_winc;
        wd_s = vif.fifo_wdata;
        r0_s = vif.req0_ready;
        r1_s = vif.req1_ready;
        a0   = vif.req0_valid & r0_s;
        a1   = vif.req1_valid & r1_s;
        if (!rst && w_s) fifo_q.push_back(wd_s);
        @(posedge clk);
        #1;
        if (a0) begin
            vif.req0_data = vif.req0_data + 8'd1;
            rem0--;
        end
        if (a1) begin
            vif.req1_data = vif.req1_data + 8'd1;
            rem1--;
        end
        drive();
    endtask

    task automatic do_reset(input int n0, input logic [7:0] d0,
                            input int n1, input logic [7:0] d1);
        rst = 1'b1;
        vif.fifo_wfull = 1'b0;
        rem0 = n0;
        rem1 = n1;
        vif.req0_data = d0;
        vif.req1_data = d1;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_q.delete();
    endtask

    task automatic check_queue(input string name);
        total++;
        if (fifo_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s size: got %0d want %0d", name, fifo_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < fifo_q.size(); i++) begin
            total++;
            if (fifo_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s word%0d: got %h want %h", name, i, fifo_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vif.fifo_wfull = 1'b0;
        rem0 = 10;
        rem1 = 10;
        vif.req0_data = 8'h01;
        vif.req1_data = 8'h02;
        drive();
        @(negedge clk);
        total++;
        if (vif.grant !== 2'b00) begin
            bad++;
            $display("FAIL rst_grant: got %b want 00", vif.grant);
        end
        total++;
        if (vif.fifo_winc !== 1'b0) begin
            bad++;
            $display("FAIL rst_winc: got %b want 0", vif.fifo_winc);
        end
        total++;
        if (vif.fifo_wdata !== 8'h00) begin
            bad++;
            $display("FAIL rst_wdata: got %h want 00", vif.fifo_wdata);
        end
        total++;
        if ({vif.req0_ready, vif.req1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL rst_ready: got %b want 00", {vif.req0_ready, vif.req1_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        total++;
        if (g_s !== 2'b00) begin
            bad++;
            $display("FAIL rst_idle: got %b want 00", g_s);
        end
        cycle();
        total++;
        if (g_s !== 2'b01) begin
            bad++;
            $display("FAIL rst_first: got %b want 01", g_s);
        end
    endtask

    task automatic test_round_robin();
        int per;
        logic [1:0] eg;
        logic [7:0] base;
        per = 4 + TAGN + 1;
        do_reset(100, 8'h10, 100, 8'h20);
        for (int k = 0; k < 3 * per; k++) begin
            cycle();
            if (k % per == 0) eg = 2'b00;
            else eg = ((k / per) % 2 == 1) ? 2'b10 : 2'b01;
            total++;
            if (g_s !== eg) begin
                bad++;
                $display("FAIL rr_grant c%0d: got %b want %b", k, g_s, eg);
            end
        end
        exp_q.delete();
        for (int b = 0; b < 3; b++) begin
            base = (b % 2 == 1) ? 8'h20 : 8'h10;
            if (TAGN == 1) exp_q.push_back(8'hA0 | 8'(b % 2));
            for (int i = 0; i < 4; i++) exp_q.push_back(base + 8'(4 * (b / 2) + i));
        end
        check_queue("rr");
    endtask

    task automatic test_backpressure();
        do_reset(100, 8'h10, 100, 8'h20);
        cycle();
        if (TAGN == 1) cycle();
        cycle();
        cycle();
        vif.fifo_wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            total++;
            if (w_s !== 1'b0 || r0_s !== 1'b0 || g_s !== 2'b01) begin
                bad++;
                $display("FAIL bp_hold c%0d: got winc=%b rdy=%b g=%b want 0 0 01",
                         k, w_s, r0_s, g_s);
            end
        end
        vif.fifo_wfull = 1'b0;
        cycle();
        total++;
        if (w_s !== 1'b1 || wd_s !== 8'h12) begin
            bad++;
            $display("FAIL bp_w3: got %b/%h want 1/12", w_s, wd_s);
        end
        cycle();
        total++;
        if (w_s !== 1'b1 || wd_s !== 8'h13) begin
            bad++;
            $display("FAIL bp_w4: got %b/%h want 1/13", w_s, wd_s);
        end
        cycle();
        total++;
        if (g_s !== 2'b00) begin
            bad++;
            $display("FAIL bp_idle: got %b want 00", g_s);
        end
        cycle();
        total++;
        if (g_s !== 2'b10 || wd_s !== ((TAGN == 1) ? 8'hA1 : 8'h20)) begin
            bad++;
            $display("FAIL bp_rotate: got %b/%h want 10/%h", g_s, wd_s,
                     (TAGN == 1) ? 8'hA1 : 8'h20);
        end
    endtask

    task automatic test_short_burst();
        do_reset(0, 8'h40, 2, 8'h30);
        cycle();
        if (TAGN == 1) cycle();
        cycle();
        cycle();
        cycle();
        total++;
        if (g_s !== 2'b10 || w_s !== 1'b0) begin
            bad++;
            $display("FAIL sb_release: got g=%b winc=%b want 10 0", g_s, w_s);
        end
        rem0 = 1;
        rem1 = 1;
        vif.req1_data = 8'h50;
        drive();
        cycle();
        total++;
        if (g_s !== 2'b00) begin
            bad++;
            $display("FAIL sb_idle: got %b want 00", g_s);
        end
        cycle();
        total++;
        if (g_s !== 2'b01) begin
            bad++;
            $display("FAIL sb_tie: got %b want 01", g_s);
        end
        for (int k = 0; k < 8; k++) cycle();
        exp_q.delete();
        if (TAGN == 1) exp_q.push_back(8'hA1);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        if (TAGN == 1) exp_q.push_back(8'hA0);
        exp_q.push_back(8'h40);
        if (TAGN == 1) exp_q.push_back(8'hA1);
        exp_q.push_back(8'h50);
        check_queue("sb");
    endtask

    task automatic test_tag();
        do_reset(0, 8'h66, 1, 8'h55);
        for (int k = 0; k < 5; k++) cycle();
        rem0 = 1;
        drive();
        for (int k = 0; k < 5; k++) cycle();
        exp_q.delete();
        if (TAGN == 1) exp_q.push_back(8'hA1);
        exp_q.push_back(8'h55);
        if (TAGN == 1) exp_q.push_back(8'hA0);
        exp_q.push_back(8'h66);
        check_queue("tag");
    endtask

    task automatic test_reset_mid();
        do_reset(4, 8'h70, 0, 8'h00);
        cycle();
        if (TAGN == 1) cycle();
        cycle();
        total++;
        if (w_s !== 1'b1 || wd_s !== 8'h70) begin
            bad++;
            $display("FAIL rm_w1: got %b/%h want 1/70", w_s, wd_s);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (vif.fifo_winc !== 1'b0 || vif.req0_ready !== 1'b0 || vif.grant !== 2'b00) begin
            bad++;
            $display("FAIL rm_drop: got winc=%b rdy=%b g=%b want 0 0 00",
                     vif.fifo_winc, vif.req0_ready, vif.grant);
        end
        @(posedge clk);
        #1;
        rem0 = 0;
        drive();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        exp_q.delete();
        if (TAGN == 1) exp_q.push_back(8'hA0);
        exp_q.push_back(8'h70);
        check_queue("rm");
    endtask

    initial begin
        vif.req0_valid = 1'b0;
        vif.req1_valid = 1'b0;
        vif.req0_data  = 8'h00;
        vif.req1_data  = 8'h00;
        vif.fifo_wfull = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_short_burst();
        test_tag();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
